// File: rtl/vga_wr_arbiter_if.sv
// Requester and Avalon-MM write-master bundle for vga_wr_arbiter.
// The arbiter connects through the master modport; the requesters and the SDRAM slave use the slave modport.
interface vga_wr_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic              rq0_valid;
    logic [ADDR_W-1:0] rq0_addr;
    logic [DATA_W-1:0] rq0_data;
    logic              rq0_ready;
    logic              rq1_valid;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq1_data;
    logic              rq1_ready;
    logic [ADDR_W-1:0] avm_address;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_write;
    logic              avm_waitrequest;
    logic              owner;

    modport master (
        input  rq0_valid, rq0_addr, rq0_data,
        output rq0_ready,
        input  rq1_valid, rq1_addr, rq1_data,
        output rq1_ready,
        output avm_address, avm_writedata, avm_write,
        input  avm_waitrequest,
        output owner
    );

    modport slave (
        output rq0_valid, rq0_addr, rq0_data,
        input  rq0_ready,
        output rq1_valid, rq1_addr, rq1_data,
        input  rq1_ready,
        input  avm_address, avm_writedata, avm_write,
        output avm_waitrequest,
        input  owner
    );
endinterface

// File: rtl/vga_wr_arbiter.sv
// Two-requester round-robin write arbiter with bounded burst hold, feeding one registered Avalon-MM write master.
// Defining VGA_WR_ARB_STATS_EN adds accept and stall counters with a synchronous clear.
module vga_wr_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    vga_wr_arbiter_if.master   bus
`ifdef VGA_WR_ARB_STATS_EN
    ,
    input  logic               stat_clr,
    output logic [31:0]        stat_cnt0,
    output logic [31:0]        stat_cnt1,
    output logic [31:0]        stat_stall
`endif
);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_write;
    logic              r_owner;
    logic              r_last_grant;
    logic [7:0]        r_hold_cnt;

    logic w_slot_free;
    logic w_pick;
    logic w_rdy0;
    logic w_rdy1;
    logic w_acc0;
    logic w_acc1;
    logic w_acc;

    assign w_slot_free = !r_write || !bus.avm_waitrequest;

    // A zero hold count means the previous owner let go, so the other side gets its turn.
    always_comb begin
        w_pick = r_last_grant;
        if (bus.rq0_valid && !bus.rq1_valid) begin
            w_pick = 1'b0;
        end else if (bus.rq1_valid && !bus.rq0_valid) begin
            w_pick = 1'b1;
        end else if (bus.rq0_valid && bus.rq1_valid) begin
            if (r_hold_cnt == 8'd0 || r_hold_cnt >= HOLD_LIM) begin
                w_pick = !r_last_grant;
            end else begin
                w_pick = r_last_grant;
            end
        end
    end

    assign w_rdy0 = !reset && w_slot_free && !w_pick && bus.rq0_valid;
    assign w_rdy1 = !reset && w_slot_free &&  w_pick && bus.rq1_valid;
    assign w_acc0 = w_rdy0;
    assign w_acc1 = w_rdy1;
    assign w_acc  = w_acc0 || w_acc1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_data       <= '0;
            r_write      <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_hold_cnt   <= 8'd0;
        end else if (w_acc) begin
            r_addr       <= w_acc1 ? bus.rq1_addr : bus.rq0_addr;
            r_data       <= w_acc1 ? bus.rq1_data : bus.rq0_data;
            r_write      <= 1'b1;
            r_owner      <= w_acc1;
            r_last_grant <= w_acc1;
            if (w_acc1 == r_last_grant) begin
                if (r_hold_cnt != 8'hFF) begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                end
            end else begin
                r_hold_cnt <= 8'd1;
            end
        end else begin
            if (w_slot_free) begin
                r_write <= 1'b0;
            end
            if (!bus.rq0_valid && !bus.rq1_valid) begin
                r_hold_cnt <= 8'd0;
            end
        end
    end

    assign bus.rq0_ready     = w_rdy0;
    assign bus.rq1_ready     = w_rdy1;
    assign bus.avm_address   = r_addr;
    assign bus.avm_writedata = r_data;
    assign bus.avm_write     = r_write;
    assign bus.owner         = r_owner;

`ifdef VGA_WR_ARB_STATS_EN
    logic [31:0] r_stat_cnt0;
    logic [31:0] r_stat_cnt1;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            r_stat_cnt0  <= 32'd0;
            r_stat_cnt1  <= 32'd0;
            r_stat_stall <= 32'd0;
        end else begin
            if (w_acc0) begin
                r_stat_cnt0 <= r_stat_cnt0 + 32'd1;
            end
            if (w_acc1) begin
                r_stat_cnt1 <= r_stat_cnt1 + 32'd1;
            end
            if (r_write && bus.avm_waitrequest) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_cnt0  = r_stat_cnt0;
    assign stat_cnt1  = r_stat_cnt1;
    assign stat_stall = r_stat_stall;
`endif
endmodule
